// File: rtl/i2s_filtr_pkg.sv
// Shared constants, slot geometry and handshake state encoding for the
// codec-side I2S interface of the audio filter chain.
package i2s_filtr_pkg;

    localparam int DATA_SIZE  = 24;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    localparam int BIT_CNT_W = $clog2(FRAME_BITS);
    localparam int POS_W     = $clog2(SLOT_BITS);

    typedef logic [POS_W-1:0] slot_pos_t;

    // Standard I2S: MSB one BCLK after the word-select change, hand-off
    // on the first bit position after the LSB.
    localparam slot_pos_t SLOT_FIRST_BIT = 5'd1;
    localparam slot_pos_t SLOT_LAST_BIT  = 5'd24;
    localparam slot_pos_t HANDOFF_BIT    = 5'd25;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_WAIT = 2'd1,
        H_CAPT = 2'd2
    } hs_state_t;

    function automatic logic in_data_window(input slot_pos_t p);
        return (p >= SLOT_FIRST_BIT) && (p <= SLOT_LAST_BIT);
    endfunction

endpackage

// File: rtl/i2s_filtr_if_clkgen.sv
// BCLK / LRCLK generator. Divides clk down to BCLK, counts bits in the
// 64-bit frame and produces one-clk strobes aligned to the BCLK edges.
module i2s_filtr_if_clkgen
    import i2s_filtr_pkg::*;
#(
    parameter int BCLK_DIV = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 bclk,
    output logic                 rise_stb,
    output logic                 fall_stb,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 lrclk
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tc;

    // Strobes are high in the clk cycle whose closing edge toggles bclk.
    assign tc       = (div_cnt == DIV_LAST);
    assign rise_stb = tc & ~bclk;
    assign fall_stb = tc &  bclk;

    // Word select is the frame counter MSB, so it moves with falling BCLK.
    assign lrclk = bit_cnt[BIT_CNT_W-1];

    // Divider, bit clock and frame bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_filtr_if.sv
// I2S master toward the codec: deserialises the left ADC sample, hands it
// to the filter once per frame and serialises the filtered result to the
// DAC (both slots) in the following frame.
//
// Filter handshake: filt_sample_trig is a one-clk valid with no ready;
// filt_data_in holds its value until the next hand-off. The filter answers
// with a one-clk filt_done and presents its result on filt_data_out one clk
// later. A hand-off arriving while a request is still outstanding is
// dropped and latched into the sticky overrun flag.
module i2s_filtr_if #(
    parameter int DATA_SIZE = 24,
    parameter int BCLK_DIV  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        i2s_bclk,
    output logic                        i2s_lrclk,
    input  logic                        i2s_sdin,
    output logic                        i2s_sdout,
    output logic signed [DATA_SIZE-1:0] filt_data_in,
    output logic                        filt_sample_trig,
    input  logic                        filt_done,
    input  logic signed [DATA_SIZE-1:0] filt_data_out,
    output logic                        overrun
);

    import i2s_filtr_pkg::*;

    logic                 rise_stb;
    logic                 fall_stb;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt_nxt;
    slot_pos_t            pos;
    slot_pos_t            pos_nxt;
    slot_pos_t            tx_idx;
    logic                 handoff;
    hs_state_t            h_state;
    logic [DATA_SIZE-1:0] rx_shift;
    logic [DATA_SIZE-1:0] tx_word;
    logic [DATA_SIZE-1:0] result_reg;

    i2s_filtr_if_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .bclk     (i2s_bclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .bit_cnt  (bit_cnt),
        .lrclk    (i2s_lrclk)
    );

    // Current slot position, and the position the next falling edge enters.
    assign pos         = bit_cnt[POS_W-1:0];
    assign bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
    assign pos_nxt     = bit_cnt_nxt[POS_W-1:0];
    assign tx_idx      = POS_W'(DATA_SIZE) - pos_nxt;
    assign handoff     = rise_stb & ~i2s_lrclk & (pos == HANDOFF_BIT);

    // Left-slot receive shifter, MSB first; right slot is not used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_shift <= '0;
        end else if (rise_stb && !i2s_lrclk && in_data_window(pos)) begin
            rx_shift <= {rx_shift[DATA_SIZE-2:0], i2s_sdin};
        end
    end

    // Filter handshake FSM; filt_done is evaluated before the hand-off so a
    // coincident hand-off sees the pre-transition state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_state          <= H_IDLE;
            filt_sample_trig <= 1'b0;
            filt_data_in     <= '0;
            result_reg       <= '0;
            overrun          <= 1'b0;
        end else begin
            filt_sample_trig <= 1'b0;
            case (h_state)
                H_WAIT: begin
                    if (filt_done) begin
                        h_state <= H_CAPT;
                    end
                end
                H_CAPT: begin
                    result_reg <= filt_data_out;
                    h_state    <= H_IDLE;
                end
                default: ;
            endcase
            if (handoff) begin
                if (h_state == H_IDLE) begin
                    filt_data_in     <= rx_shift;
                    filt_sample_trig <= 1'b1;
                    h_state          <= H_WAIT;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // Transmit: reload the word at frame start, shift bits out on falling BCLK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_word   <= '0;
            i2s_sdout <= 1'b0;
        end else if (fall_stb) begin
            if (bit_cnt_nxt == '0) begin
                tx_word <= result_reg;
            end
            if (in_data_window(pos_nxt)) begin
                i2s_sdout <= tx_word[tx_idx];
            end else begin
                i2s_sdout <= 1'b0;
            end
        end
    end

endmodule
